// File: rtl/cl_pattern_gen.sv
// rtl/cl_pattern_gen.sv - Camera Link test-pattern video source (fval/lval/dval framing plus selectable pixel patterns)
// Optional feature macro: CL_PATGEN_DVAL_THROTTLE_EN (drops dval on every 4th active cycle of a line).
module cl_pattern_gen #(
  parameter int DATA_W     = 24,
  parameter int ACTIVE_PIX = 85,
  parameter int HBLANK     = 8,
  parameter int LINES      = 4,
  parameter int FV_LEAD    = 2,
  parameter int VBLANK     = 8
) (
  input  logic              CL_clk,
  input  logic              CL_rst,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W+3:0] CL_data,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  localparam int BLK_MAX = (FV_LEAD > HBLANK) ? ((FV_LEAD > VBLANK) ? FV_LEAD : VBLANK)
                                              : ((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam int BW = cnt_w(BLK_MAX);
  localparam int XW = cnt_w(ACTIVE_PIX);
  localparam int YW = cnt_w(LINES);

  localparam logic [BW-1:0] LEAD_LAST = BW'(FV_LEAD - 1);
  localparam logic [BW-1:0] HBL_LAST  = BW'(HBLANK - 1);
  localparam logic [BW-1:0] VBL_LAST  = BW'(VBLANK - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(ACTIVE_PIX - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_ACTIVE,
    S_HBL,
    S_VBL
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       blk_q, blk_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [DATA_W-1:0]   idx_q, idx_d;
  logic [1:0]          pat_q, pat_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic [DATA_W+3:0]   data_q;
  logic                busy_q;

  logic                gap;
  logic                fval_n, lval_n, dval_n;
  logic [DATA_W-1:0]   pix_n;
  logic                x_b3, y_b3;

`ifdef CL_PATGEN_DVAL_THROTTLE_EN
  // Phase restarts at every line start, so cycles 3, 7, 11... of a line are the gaps.
  logic [1:0] ph_q, ph_d;

  assign gap = (state_q == S_ACTIVE) && (ph_q == 2'd3);

  always_comb begin
    ph_d = ph_q + 2'd1;
    if (state_q != S_ACTIVE) begin
      ph_d = 2'd0;
    end
  end

  always_ff @(posedge CL_clk) begin
    if (CL_rst) begin
      ph_q <= 2'd0;
    end else begin
      ph_q <= ph_d;
    end
  end
`else
  assign gap = 1'b0;
`endif

  if (XW > 3) begin : g_x3
    assign x_b3 = x_q[3];
  end else begin : g_x3_zero
    assign x_b3 = 1'b0;
  end

  if (YW > 3) begin : g_y3
    assign y_b3 = y_q[3];
  end else begin : g_y3_zero
    assign y_b3 = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LEAD;
          pat_d   = pattern_sel;
          blk_d   = '0;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
        end
      end
      S_LEAD: begin
        if (blk_q == LEAD_LAST) begin
          state_d = S_ACTIVE;
          blk_d   = '0;
          x_d     = '0;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      S_ACTIVE: begin
        // x and the frame index only advance on cycles that carry a valid pixel.
        if (!gap) begin
          idx_d = idx_q + DATA_W'(1);
          if (x_q == X_LAST) begin
            x_d   = '0;
            blk_d = '0;
            if (y_q == Y_LAST) begin
              state_d = S_VBL;
            end else begin
              state_d = S_HBL;
              y_d     = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_HBL: begin
        if (blk_q == HBL_LAST) begin
          state_d = S_ACTIVE;
          blk_d   = '0;
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      S_VBL: begin
        if (blk_q == VBL_LAST) begin
          fcnt_d = fcnt_q + 16'd1;
          blk_d  = '0;
          if (enable) begin
            state_d = S_LEAD;
            pat_d   = pattern_sel;
            x_d     = '0;
            y_d     = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          blk_d = blk_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fval_n = 1'b0;
    lval_n = 1'b0;
    dval_n = 1'b0;
    pix_n  = '0;
    case (state_q)
      S_LEAD, S_HBL: fval_n = 1'b1;
      S_ACTIVE: begin
        fval_n = 1'b1;
        lval_n = 1'b1;
        dval_n = !gap;
      end
      default: ;
    endcase
    if (dval_n) begin
      case (pat_q)
        2'd0:    pix_n = idx_q;
        2'd1:    pix_n = DATA_W'(x_q);
        2'd2:    pix_n = DATA_W'(y_q);
        default: pix_n = {DATA_W{x_b3 ^ y_b3}};
      endcase
    end
  end

  always_ff @(posedge CL_clk) begin
    if (CL_rst) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      pat_q   <= 2'd0;
      fcnt_q  <= 16'd0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      fcnt_q  <= fcnt_d;
      // Outputs are a registered decode of the current state, one cycle behind it.
      data_q  <= {1'b0, dval_n, fval_n, lval_n, pix_n};
      busy_q  <= (state_q != S_IDLE);
    end
  end

  assign CL_data   = data_q;
  assign frame_cnt = fcnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cl_pattern_gen.sv
// tb/tb_cl_pattern_gen.sv - scoreboard bench for cl_pattern_gen (default geometry plus a 32x9 checkerboard instance)
module tb_cl_pattern_gen;

`ifdef CL_PATGEN_DVAL_THROTTLE_EN
  localparam int LINE_CYC = 113;
`else
  localparam int LINE_CYC = 85;
`endif
  localparam int FV_HI = 2 + 4 * LINE_CYC + 3 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en0, en1, mon_en;
  logic [1:0]  ps0, ps1;
  logic [27:0] d0;
  logic [15:0] fc0;
  logic        b0;
  logic [11:0] d1;
  logic [15:0] fc1;
  logic        b1;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] exp0_q[$];
  logic [7:0]  exp1_q[$];

  wire dv0 = d0[26];
  wire fv0 = d0[25];
  wire lv0 = d0[24];
  wire dv1 = d1[10];
  wire fv1 = d1[9];
  wire lv1 = d1[8];

  cl_pattern_gen dut0 (
    .CL_clk(clk), .CL_rst(rst), .enable(en0), .pattern_sel(ps0),
    .CL_data(d0), .frame_cnt(fc0), .busy(b0)
  );

  cl_pattern_gen #(
    .DATA_W(8), .ACTIVE_PIX(32), .HBLANK(2), .LINES(9), .FV_LEAD(1), .VBLANK(3)
  ) dut1 (
    .CL_clk(clk), .CL_rst(rst), .enable(en1), .pattern_sel(ps1),
    .CL_data(d1), .frame_cnt(fc1), .busy(b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame0(input int pat, input int nlines);
    int idx = 0;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < 85; x++) begin
        case (pat)
          0:       exp0_q.push_back(24'(idx));
          1:       exp0_q.push_back(24'(x));
          2:       exp0_q.push_back(24'(y));
          default: exp0_q.push_back((((x >> 3) ^ (y >> 3)) & 1) != 0 ? 24'hFFFFFF : 24'h0);
        endcase
        idx++;
      end
    end
  endtask

  task automatic push_frame1_checker();
    for (int y = 0; y < 9; y++) begin
      for (int x = 0; x < 32; x++) begin
        exp1_q.push_back((((x >> 3) ^ (y >> 3)) & 1) != 0 ? 8'hFF : 8'h00);
      end
    end
  endtask

  // Entered at a negedge showing the first fval=1 cycle; leaves at the next frame's first
  // fval=1 cycle or once busy has dropped.
  task automatic measure(output int hi, output int lo, output int nl,
                         output int lmin, output int lmax, output int nd);
    int run = 0;
    hi = 0; lo = 0; nl = 0; lmin = 1 << 30; lmax = 0; nd = 0;
    while (fv0 && hi < 5000) begin
      hi++;
      if (dv0) nd++;
      if (lv0) run++;
      else if (run != 0) begin
        nl++;
        if (run < lmin) lmin = run;
        if (run > lmax) lmax = run;
        run = 0;
      end
      @(negedge clk);
    end
    if (run != 0) begin
      nl++;
      if (run < lmin) lmin = run;
      if (run > lmax) lmax = run;
    end
    while (!fv0 && b0 && lo < 5000) begin
      lo++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int hi, input int lo, input int nl,
                             input int lmin, input int lmax, input int nd);
    check({tag, "_fval_hi"}, hi, FV_HI);
    check({tag, "_fval_lo"}, lo, 8);
    check({tag, "_lines"}, nl, 4);
    check({tag, "_lval_min"}, lmin, LINE_CYC);
    check({tag, "_lval_max"}, lmax, LINE_CYC);
    check({tag, "_dval_cnt"}, nd, 340);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dv0) begin
        check("dut0_dval_framing", {d0[27], fv0, lv0}, 3'b011);
        if (exp0_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dut0_pixel_unexpected: got 0x%0h, expected no pixel", d0[23:0]);
        end else begin
          check("dut0_pixel", d0[23:0], exp0_q.pop_front());
        end
      end else begin
        check("dut0_blank_pixel", {d0[27], d0[23:0]}, 0);
      end
      if (dv1) begin
        check("dut1_dval_framing", {d1[11], fv1, lv1}, 3'b011);
        if (exp1_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dut1_pixel_unexpected: got 0x%0h, expected no pixel", d1[7:0]);
        end else begin
          check("dut1_pixel", d1[7:0], exp1_q.pop_front());
        end
      end else begin
        check("dut1_blank_pixel", {d1[11], d1[7:0]}, 0);
      end
    end
  end

  initial begin
    int hi, lo, nl, lmin, lmax, nd, n, nr;
    logic prev;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; ps0 = 2'd0; ps1 = 2'd0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", d0, 0);
    check("rst_busy", b0, 0);
    check("rst_frame_cnt", fc0, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Start latency, then abort the frame with reset during the first HBL.
    en0 = 1'b1;
    ps0 = 2'd0;
    push_frame0(0, 1);
    @(negedge clk);
    check("lat_fval_after_k", fv0, 0);
    @(negedge clk);
    check("lat_fval_busy_after_k1", {fv0, b0, lv0}, 3'b110);
    en0 = 1'b0;
    n = 0;
    while (!lv0 && n < 200) begin @(negedge clk); n++; end
    while (lv0 && n < 400) begin @(negedge clk); n++; end
    check("hbl_reached", {fv0, lv0}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check("hbl_rst_data", d0, 0);
    check("hbl_rst_busy", b0, 0);
    check("hbl_rst_frame_cnt", fc0, 0);
    check("hbl_rst_line0_consumed", exp0_q.size(), 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back frames: pattern 0, 0, 1, 2.
    en0 = 1'b1;
    ps0 = 2'd0;
    push_frame0(0, 4);
    push_frame0(0, 4);
    push_frame0(1, 4);
    push_frame0(2, 4);
    n = 0;
    while (!fv0 && n < 100) begin @(negedge clk); n++; end
    check("frameA_start", fv0, 1);
    measure(hi, lo, nl, lmin, lmax, nd);
    check_frame("frameA", hi, lo, nl, lmin, lmax, nd);
    check("frameA_frame_cnt", fc0, 1);
    ps0 = 2'd1;
    measure(hi, lo, nl, lmin, lmax, nd);
    check_frame("frameB", hi, lo, nl, lmin, lmax, nd);
    check("frameB_frame_cnt", fc0, 2);
    ps0 = 2'd2;
    measure(hi, lo, nl, lmin, lmax, nd);
    check_frame("frameC", hi, lo, nl, lmin, lmax, nd);
    check("frameC_frame_cnt", fc0, 3);
    ps0 = 2'd3;

    // Frame D: enable dropped during line 2 must not truncate it.
    nr = 0; n = 0; prev = 1'b0;
    while (nr < 3 && n < 2000) begin
      if (lv0 && !prev) nr++;
      prev = lv0;
      if (nr < 3) begin @(negedge clk); n++; end
    end
    check("frameD_line2_reached", nr, 3);
    en0 = 1'b0;
    n = 0;
    while (fv0 && n < 2000) begin @(negedge clk); n++; end
    check("frameD_fval_fell", fv0, 0);
    n = 0;
    while (b0 && n < 100) begin n++; @(negedge clk); end
    check("frameD_vbl_busy_cycles", n, 8);
    check("frameD_frame_cnt", fc0, 4);
    n = 0;
    repeat (400) begin
      @(negedge clk);
      if (fv0 || b0) n++;
    end
    check("idle_no_fval", n, 0);
    check("dut0_queue_drained", exp0_q.size(), 0);

    // Checkerboard on the 32x9 instance.
    en1 = 1'b1;
    ps1 = 2'd3;
    push_frame1_checker();
    n = 0;
    while (!fv1 && n < 50) begin @(negedge clk); n++; end
    check("dut1_start", fv1, 1);
    en1 = 1'b0;
    n = 0;
    while (b1 && n < 1000) begin @(negedge clk); n++; end
    check("dut1_done", b1, 0);
    check("dut1_frame_cnt", fc1, 1);
    check("dut1_queue_drained", exp1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
